multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

- Moore control state machine for the multicycle MIPS datapath.
- Sequences fetch, decode, execute, memory and write-back for the supported instruction subset.
- Drives every datapath select and write-enable, including the 3-bit AluSrcB code consumed by the ALU source-B mux.
- Sits between the instruction register fields and ALU Zero flag (inputs) and all datapath muxes/registers (outputs).

## Interface
Parameters:
- MEM_WAIT, 2: extra wait cycles before memory read data is valid. Fetch and load-read phases each last MEM_WAIT+1 cycles.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  one clock; reset is synchronous and active-high
- Opcode  in  6  IR[31:26]
- Funct  in  6  IR[5:0]
- Zero  in  1  ALU zero flag
- PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, MDRWrite, ABWrite, AluOutWrite, RegWrite  out  1 each  enables/selects
- AluSrcA  out  2  0=PC, 1=RegA
- AluSrcB  out  3  0=RegB, 1=const 4, 2=ExtendedOffset, 3=RegMDR, 4=ExtendedOffsetLeft2
- AluOp  out  3  000=pass A, 001=add, 010=sub, 011=and, 100=or
- PCSource  out  2  0=ALU result, 1=AluOut, 2=jump target
- RegDst  out  2  0=rt, 1=rd, 2=$29
- MemToReg  out  2  0=AluOut, 1=MDR, 2=const 227

## Operation
- All outputs decode from the state register and wait counter only (Moore). Any output not listed for a state is 0.
- States and transitions:
  - RESET: RegWrite=1, RegDst=2, MemToReg=2 (writes 227 into $29). Held while reset=1. Goes to FETCH on the first edge with reset=0.
  - FETCH: IorD=0, AluSrcA=0, AluSrcB=1, AluOp=001. Counter runs 0..MEM_WAIT. On the last count: IRWrite=1, PCWrite=1, PCSource=0, counter cleared, go to DECODE.
  - DECODE: ABWrite=1, AluSrcA=0, AluSrcB=4, AluOp=001, AluOutWrite=1 (branch target). Dispatch by Opcode:
    - 0x00 -> EXEC_R
    - 0x08 -> EXEC_I
    - 0x23 or 0x2B -> MEM_ADDR
    - 0x04 -> BRANCH
    - 0x02 -> JUMP
    - anything else -> FETCH (no-op)
  - EXEC_R: AluSrcA=1, AluSrcB=0, AluOutWrite=1. AluOp by Funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or → WB_R. Unsupported Funct: AluOutWrite=0 → FETCH.
  - WB_R: RegWrite=1, RegDst=1, MemToReg=0 → FETCH.
  - EXEC_I: AluSrcA=1, AluSrcB=2, AluOp=001, AluOutWrite=1 → WB_I.
  - WB_I: RegWrite=1, RegDst=0, MemToReg=0 → FETCH.
  - MEM_ADDR: AluSrcA=1, AluSrcB=2, AluOp=001, AluOutWrite=1. Opcode 0x23 → MEM_READ; 0x2B → MEM_WRITE.
  - MEM_READ: IorD=1. Counter runs 0..MEM_WAIT. On the last count: MDRWrite=1 → WB_LOAD.
  - WB_LOAD: RegWrite=1, RegDst=0, MemToReg=1 → FETCH.
  - MEM_WRITE: IorD=1, MemWrite=1 for exactly one cycle → FETCH.
  - BRANCH: AluSrcA=1, AluSrcB=0, AluOp=010, PCWriteCond=1, PCSource=1 → FETCH.
    - The datapath gates the PC load with Zero.
    - The FSM also samples Zero only to assert PCWrite=0. PCWrite stays 0 here.
  - JUMP: PCWrite=1, PCSource=2 → FETCH.
- Opcode and Funct are read only in DECODE/EXEC_R/MEM_ADDR. IR is stable there because IRWrite=0 outside FETCH.

## Timing
- Reset value:
  - All outputs are 0 except RegWrite=1, RegDst=2, MemToReg=2.
  - State=RESET, counter=0.
- Reset mid-instruction: the next edge forces RESET and clears the counter. No further MemWrite/PCWrite/IRWrite is issued for the aborted instruction.
- Cycle counts from first FETCH cycle to the next FETCH, with MEM_WAIT=2:
  - R-type and addi: 6
  - lw: 9
  - sw: 6
  - beq: 5
  - j: 5
  - unsupported opcode: 4
- General formulas:
  - fetch = MEM_WAIT+1
  - lw = 2·(MEM_WAIT+1)+3
- MemWrite, IRWrite, MDRWrite and RegWrite are asserted for exactly one cycle per instruction, except RegWrite held in RESET.
- MEM_WAIT=0: FETCH and MEM_READ last one cycle each. The counter never increments.

## Test plan
- Reset held 3 cycles, then released:
  - During reset: RegWrite=1, RegDst=2, MemToReg=2 each cycle.
  - Next cycle: FETCH with AluSrcB=1. IRWrite=1 and PCWrite=1 in the third FETCH cycle.
- Opcode=0x00, Funct=0x22:
  - EXEC_R shows AluSrcB=0, AluOp=010.
  - RegWrite=1 with RegDst=1 at cycle 6. FETCH resumes at cycle 7.
- Opcode=0x23:
  - MEM_ADDR shows AluSrcB=2.
  - IorD=1 for 3 cycles with MDRWrite only on the third.
  - WB_LOAD shows MemToReg=1. Total 9 cycles.
- Opcode=0x2B: MemWrite=1 for exactly one cycle with IorD=1. No RegWrite. 6 cycles total.
- Opcode=0x04 with Zero=1, then Zero=0:
  - Both cases: DECODE shows AluSrcB=4 and AluOutWrite=1.
  - BRANCH shows PCWriteCond=1, PCSource=1, PCWrite=0.
  - 5 cycles each.
- Reset asserted during MEM_READ count 1 of a lw: no MDRWrite or RegWrite(RegDst=0). RESET outputs appear next cycle.
- Opcode=0x3F: returns to FETCH after DECODE (4 cycles) with no write enables beyond fetch/decode.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for the multicycle MIPS datapath: fetch, decode, execute,
// memory and write-back sequencing for R-type, addi, lw, sw, beq and j.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_RESET    | held in reset; writes constant 227 into $29
// S_FETCH    | read instruction memory, PC+4; IR/PC load on last count
// S_DECODE   | load A/B, compute branch target into AluOut, dispatch
// S_EXEC_R   | R-type ALU operation selected by Funct
// S_WB_R     | write AluOut to rd
// S_EXEC_I   | addi: RegA + sign-extended immediate
// S_WB_I     | write AluOut to rt
// S_MEM_ADDR | lw/sw effective address
// S_MEM_READ | data memory read; MDR load on last count
// S_WB_LOAD  | write MDR to rt
// S_MEM_WRITE| single-cycle data memory write
// S_BRANCH   | beq compare; datapath gates the PC load with Zero
// S_JUMP     | load PC with jump target
module multicycle_control_fsm #(
    parameter int MEM_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MDRWrite,
    output logic       ABWrite,
    output logic       AluOutWrite,
    output logic       RegWrite,
    output logic [1:0] AluSrcA,
    output logic [2:0] AluSrcB,
    output logic [2:0] AluOp,
    output logic [1:0] PCSource,
    output logic [1:0] RegDst,
    output logic [1:0] MemToReg
);

    localparam int CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_WAIT);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;

    typedef enum logic [3:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_WB_R,
        S_EXEC_I,
        S_WB_I,
        S_MEM_ADDR,
        S_MEM_READ,
        S_WB_LOAD,
        S_MEM_WRITE,
        S_BRANCH,
        S_JUMP
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_next_cnt;
    logic          w_cnt_last;
    logic          w_funct_ok;
    logic [2:0]    w_funct_aluop;

    assign w_cnt_last = (r_cnt == CNT_LAST);

    always_comb begin
        w_funct_ok    = 1'b1;
        w_funct_aluop = ALU_PASS;
        case (Funct)
            FN_ADD:  w_funct_aluop = ALU_ADD;
            FN_SUB:  w_funct_aluop = ALU_SUB;
            FN_AND:  w_funct_aluop = ALU_AND;
            FN_OR:   w_funct_aluop = ALU_OR;
            default: w_funct_ok    = 1'b0;
        endcase
    end

    // Reset wins over everything, aborting any instruction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RESET;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = '0;
        case (r_state)
            S_RESET: w_next_state = S_FETCH;
            S_FETCH: begin
                if (w_cnt_last) begin
                    w_next_state = S_DECODE;
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE:      w_next_state = S_EXEC_R;
                    OP_ADDI:       w_next_state = S_EXEC_I;
                    OP_LW, OP_SW:  w_next_state = S_MEM_ADDR;
                    OP_BEQ:        w_next_state = S_BRANCH;
                    OP_J:          w_next_state = S_JUMP;
                    default:       w_next_state = S_FETCH;
                endcase
            end
            S_EXEC_R:    w_next_state = w_funct_ok ? S_WB_R : S_FETCH;
            S_WB_R:      w_next_state = S_FETCH;
            S_EXEC_I:    w_next_state = S_WB_I;
            S_WB_I:      w_next_state = S_FETCH;
            S_MEM_ADDR: begin
                if (Opcode == OP_LW) begin
                    w_next_state = S_MEM_READ;
                end else if (Opcode == OP_SW) begin
                    w_next_state = S_MEM_WRITE;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_MEM_READ: begin
                if (w_cnt_last) begin
                    w_next_state = S_WB_LOAD;
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            S_WB_LOAD:   w_next_state = S_FETCH;
            S_MEM_WRITE: w_next_state = S_FETCH;
            S_BRANCH:    w_next_state = S_FETCH;
            S_JUMP:      w_next_state = S_FETCH;
            default:     w_next_state = S_RESET;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MDRWrite    = 1'b0;
        ABWrite     = 1'b0;
        AluOutWrite = 1'b0;
        RegWrite    = 1'b0;
        AluSrcA     = 2'd0;
        AluSrcB     = 3'd0;
        AluOp       = ALU_PASS;
        PCSource    = 2'd0;
        RegDst      = 2'd0;
        MemToReg    = 2'd0;
        case (r_state)
            S_RESET: begin
                RegWrite = 1'b1;
                RegDst   = 2'd2;
                MemToReg = 2'd2;
            end
            S_FETCH: begin
                AluSrcB = 3'd1;
                AluOp   = ALU_ADD;
                if (w_cnt_last) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                end
            end
            S_DECODE: begin
                ABWrite     = 1'b1;
                AluSrcB     = 3'd4;
                AluOp       = ALU_ADD;
                AluOutWrite = 1'b1;
            end
            S_EXEC_R: begin
                AluSrcA     = 2'd1;
                AluOp       = w_funct_aluop;
                AluOutWrite = w_funct_ok;
            end
            S_WB_R: begin
                RegWrite = 1'b1;
                RegDst   = 2'd1;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                AluSrcA     = 2'd1;
                AluSrcB     = 3'd2;
                AluOp       = ALU_ADD;
                AluOutWrite = 1'b1;
            end
            S_WB_I: RegWrite = 1'b1;
            S_MEM_READ: begin
                IorD     = 1'b1;
                MDRWrite = w_cnt_last;
            end
            S_WB_LOAD: begin
                RegWrite = 1'b1;
                MemToReg = 2'd1;
            end
            S_MEM_WRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_BRANCH: begin
                AluSrcA     = 2'd1;
                AluOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'd1;
                // Taken/not-taken is resolved by the datapath; PC never loads unconditionally here.
                PCWrite     = Zero & 1'b0;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'd2;
            end
            default: begin
                RegWrite = 1'b1;
                RegDst   = 2'd2;
                MemToReg = 2'd2;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: each issued instruction pushes its expected per-cycle
// control vectors; a monitor compares one vector per cycle on the falling edge.
module tb_multicycle_control_fsm;

    localparam int MW = 2;

    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic       iord;
        logic       memw;
        logic       irw;
        logic       mdrw;
        logic       abw;
        logic       aluoutw;
        logic       regw;
        logic [1:0] srca;
        logic [2:0] srcb;
        logic [2:0] aluop;
        logic [1:0] pcsrc;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
    } ctl_t;

    logic       clk;
    logic       reset;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic       PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, MDRWrite;
    logic       ABWrite, AluOutWrite, RegWrite;
    logic [1:0] AluSrcA;
    logic [2:0] AluSrcB;
    logic [2:0] AluOp;
    logic [1:0] PCSource;
    logic [1:0] RegDst;
    logic [1:0] MemToReg;

    ctl_t exp_q[$];
    ctl_t seq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    multicycle_control_fsm #(.MEM_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MDRWrite(MDRWrite),
        .ABWrite(ABWrite), .AluOutWrite(AluOutWrite), .RegWrite(RegWrite),
        .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluOp(AluOp),
        .PCSource(PCSource), .RegDst(RegDst), .MemToReg(MemToReg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per-phase control words straight from the instruction semantics.
    function automatic ctl_t v_reset();
        ctl_t c = '0;
        c.regw = 1'b1; c.regdst = 2'd2; c.memtoreg = 2'd2;
        return c;
    endfunction

    function automatic ctl_t v_fetch(input bit last);
        ctl_t c = '0;
        c.srcb = 3'd1; c.aluop = 3'd1;
        c.irw = last; c.pcw = last;
        return c;
    endfunction

    function automatic ctl_t v_addr_calc();
        ctl_t c = '0;
        c.srca = 2'd1; c.srcb = 3'd2; c.aluop = 3'd1; c.aluoutw = 1'b1;
        return c;
    endfunction

    task automatic gen_seq(input logic [5:0] op, input logic [5:0] fn);
        ctl_t c;
        seq.delete();
        for (int i = 0; i <= MW; i++) seq.push_back(v_fetch(i == MW));
        c = '0; c.abw = 1'b1; c.srcb = 3'd4; c.aluop = 3'd1; c.aluoutw = 1'b1;
        seq.push_back(c);
        if (op == 6'h00) begin
            c = '0; c.srca = 2'd1; c.srcb = 3'd0;
            case (fn)
                6'h20: c.aluop = 3'd1;
                6'h22: c.aluop = 3'd2;
                6'h24: c.aluop = 3'd3;
                6'h25: c.aluop = 3'd4;
                default: c.aluop = 3'd0;
            endcase
            c.aluoutw = (c.aluop != 3'd0);
            seq.push_back(c);
            if (c.aluoutw) begin
                c = '0; c.regw = 1'b1; c.regdst = 2'd1;
                seq.push_back(c);
            end
        end else if (op == 6'h08) begin
            seq.push_back(v_addr_calc());
            c = '0; c.regw = 1'b1;
            seq.push_back(c);
        end else if (op == 6'h23) begin
            seq.push_back(v_addr_calc());
            for (int i = 0; i <= MW; i++) begin
                c = '0; c.iord = 1'b1; c.mdrw = (i == MW);
                seq.push_back(c);
            end
            c = '0; c.regw = 1'b1; c.memtoreg = 2'd1;
            seq.push_back(c);
        end else if (op == 6'h2B) begin
            seq.push_back(v_addr_calc());
            c = '0; c.iord = 1'b1; c.memw = 1'b1;
            seq.push_back(c);
        end else if (op == 6'h04) begin
            c = '0; c.srca = 2'd1; c.aluop = 3'd2; c.pcwc = 1'b1; c.pcsrc = 2'd1;
            seq.push_back(c);
        end else if (op == 6'h02) begin
            c = '0; c.pcw = 1'b1; c.pcsrc = 2'd2;
            seq.push_back(c);
        end
    endtask

    // Caller is #1 into the cycle before this instruction's first FETCH.
    // abort_at>0 asserts reset during that (1-based) cycle of the instruction.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input bit z, input int abort_at);
        int n;
        int m;
        gen_seq(op, fn);
        n = seq.size();
        m = (abort_at > 0 && abort_at <= n) ? abort_at : n;
        for (int i = 0; i < m; i++) exp_q.push_back(seq[i]);
        if (m != n || abort_at == n) begin
            exp_q.push_back(v_reset());
            exp_q.push_back(v_reset());
        end
        for (int c = 1; c <= m; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                Opcode = 6'($urandom);
                Funct  = 6'($urandom);
            end
            if (c == 2) begin
                Opcode = op;
                Funct  = fn;
                Zero   = z;
            end
            if (abort_at > 0 && c == abort_at) reset = 1'b1;
        end
        if (abort_at > 0 && abort_at <= n) begin
            repeat (2) begin @(posedge clk); #1; end
            reset = 1'b0;
        end
    endtask

    // Monitor: one control word per cycle while expectations are pending.
    initial begin
        ctl_t act;
        ctl_t exp;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                act = '{PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, MDRWrite,
                        ABWrite, AluOutWrite, RegWrite, AluSrcA, AluSrcB, AluOp,
                        PCSource, RegDst, MemToReg};
                total++;
                if (act !== exp) begin
                    bad++;
                    $display("FAIL ctl_word cycle=%0d actual=%h required=%h", cyc, act, exp);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    logic [5:0] op_tab [0:5];
    logic [5:0] fn_tab [0:3];

    initial begin
        op_tab[0] = 6'h00; op_tab[1] = 6'h08; op_tab[2] = 6'h23;
        op_tab[3] = 6'h2B; op_tab[4] = 6'h04; op_tab[5] = 6'h02;
        fn_tab[0] = 6'h20; fn_tab[1] = 6'h22; fn_tab[2] = 6'h24; fn_tab[3] = 6'h25;

        reset  = 1'b1;
        Opcode = 6'h00;
        Funct  = 6'h00;
        Zero   = 1'b0;
        @(posedge clk); #1;
        repeat (3) exp_q.push_back(v_reset());
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;

        issue(6'h00, 6'h22, 1'b0, 0);
        issue(6'h23, 6'h00, 1'b0, 0);
        issue(6'h2B, 6'h00, 1'b0, 0);
        issue(6'h04, 6'h00, 1'b1, 0);
        issue(6'h04, 6'h00, 1'b0, 0);
        issue(6'h3F, 6'h00, 1'b0, 0);
        issue(6'h08, 6'h00, 1'b0, 0);
        issue(6'h02, 6'h00, 1'b0, 0);
        issue(6'h00, 6'h20, 1'b0, 0);
        issue(6'h00, 6'h24, 1'b0, 0);
        issue(6'h00, 6'h25, 1'b0, 0);
        issue(6'h00, 6'h00, 1'b0, 0);
        issue(6'h23, 6'h00, 1'b0, 7);
        issue(6'h2B, 6'h00, 1'b0, 5);

        for (int k = 0; k < 120; k++) begin
            logic [5:0] op;
            logic [5:0] fn;
            int sel;
            int ab;
            sel = $urandom_range(0, 6);
            op  = (sel == 6) ? 6'($urandom) : op_tab[sel];
            fn  = ($urandom_range(0, 4) == 4) ? 6'($urandom) : fn_tab[$urandom_range(0, 3)];
            ab  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 9) : 0;
            issue(op, fn, 1'($urandom), ab);
        end

        @(negedge clk); #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
